// File: rtl/timer_counter_if.sv
// Control/status bundle for timer_counter: the master drives configuration
// and strobes, and the slave (the counter) returns count and event flags.
interface timer_counter_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int PRESCALER_WIDTH = 8
);
    logic                       i_en;
    logic                       i_le;
    logic [DATA_WIDTH-1:0]      i_data;
    logic                       i_dir;
    logic [1:0]                 i_mode;
    logic [DATA_WIDTH-1:0]      i_limit;
    logic [PRESCALER_WIDTH-1:0] i_prescale;
    logic [DATA_WIDTH-1:0]      i_compare;
    logic                       i_clr_flags;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_tc;
    logic                       o_match;
    logic                       o_ovf;
    logic                       o_running;

    modport master (
        output i_en, i_le, i_data, i_dir, i_mode, i_limit, i_prescale,
               i_compare, i_clr_flags,
        input  o_data, o_tc, o_match, o_ovf, o_running
    );

    modport slave (
        input  i_en, i_le, i_data, i_dir, i_mode, i_limit, i_prescale,
               i_compare, i_clr_flags,
        output o_data, o_tc, o_match, o_ovf, o_running
    );
endinterface

// File: rtl/timer_counter.sv
// Up/down timer with prescaler, free-run/modulo/one-shot wrap modes,
// compare-match and terminal-count pulses, and a sticky overflow flag.
module timer_counter #(
    parameter int DATA_WIDTH      = 16,
    parameter int PRESCALER_WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    timer_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MODULO  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    logic [PRESCALER_WIDTH-1:0] pcnt;
    logic [DATA_WIDTH-1:0]      count;
    logic                       tc;
    logic                       match;
    logic                       ovf;
    logic                       running;

    mode_e                 mode;
    logic                  tick;
    logic                  step;
    logic                  term;
    logic                  expire;
    logic [DATA_WIDTH-1:0] next_count;

    assign mode = mode_e'(bus.i_mode);

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_count = count;
        expire     = 1'b0;
        tick       = bus.i_en && (pcnt == bus.i_prescale);
        step       = tick && ((mode != MODE_ONESHOT) || running);

        if (bus.i_dir)
            term = (count == '0);
        else if (mode == MODE_MODULO || mode == MODE_ONESHOT)
            term = (count >= bus.i_limit);
        else
            term = (count == ALL_ONES);

        if (!term) begin
            next_count = bus.i_dir ? count - DATA_WIDTH'(1) : count + DATA_WIDTH'(1);
        end else begin
            case (mode)
                MODE_MODULO:  next_count = bus.i_dir ? bus.i_limit : '0;
                MODE_ONESHOT: expire     = 1'b1;  // count holds at its terminal value
                default:      next_count = bus.i_dir ? ALL_ONES : '0;
            endcase
        end
    end

    // NOTE: reset is synchronous and active-low, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pcnt    <= '0;
            count   <= '0;
            tc      <= 1'b0;
            match   <= 1'b0;
            ovf     <= 1'b0;
            running <= 1'b1;
        end else begin
            tc    <= 1'b0;
            match <= 1'b0;
            if (bus.i_le) begin
                count   <= bus.i_data;
                pcnt    <= '0;
                running <= 1'b1;
                match   <= (bus.i_data == bus.i_compare);
            end else begin
                if (bus.i_en)
                    pcnt <= tick ? '0 : pcnt + PRESCALER_WIDTH'(1);
                if (step) begin
                    count <= next_count;
                    tc    <= term;
                    match <= !expire && (next_count == bus.i_compare);
                    if (expire)
                        running <= 1'b0;
                end
            end

            // A terminal step beats a simultaneous clear request.
            if (!bus.i_le && step && term)
                ovf <= 1'b1;
            else if (bus.i_clr_flags)
                ovf <= 1'b0;
        end
    end

    assign bus.o_data    = count;
    assign bus.o_tc      = tc;
    assign bus.o_match   = match;
    assign bus.o_ovf     = ovf;
    assign bus.o_running = running;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_timer_counter;
    localparam int DW   = 4;
    localparam int PW   = 3;
    localparam int MODV = 1 << DW;
    localparam int MAXV = MODV - 1;
    localparam int PMOD = 1 << PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_counter_if #(.DATA_WIDTH(DW), .PRESCALER_WIDTH(PW)) bus ();

    timer_counter #(.DATA_WIDTH(DW), .PRESCALER_WIDTH(PW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int m_data, m_pcnt, m_tc, m_match, m_ovf, m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the behaviour, derived directly from the rules.
    task automatic model_edge();
        int  mode, lim, cmp;
        bit  up, limited, tick, term, stepping;
        mode = int'(bus.i_mode);
        lim  = int'(bus.i_limit);
        cmp  = int'(bus.i_compare);
        up   = !bus.i_dir;
        if (!rst) begin
            m_data = 0; m_pcnt = 0; m_tc = 0; m_match = 0; m_ovf = 0; m_run = 1;
            return;
        end
        m_tc    = 0;
        m_match = 0;
        if (bus.i_le) begin
            m_data  = int'(bus.i_data);
            m_pcnt  = 0;
            m_run   = 1;
            m_match = (m_data == cmp);
            if (bus.i_clr_flags) m_ovf = 0;
            return;
        end
        tick     = bus.i_en && (m_pcnt == int'(bus.i_prescale));
        if (bus.i_en) m_pcnt = tick ? 0 : (m_pcnt + 1) % PMOD;
        stepping = tick && (mode != 2 || m_run == 1);
        limited  = (mode == 1 || mode == 2);
        term     = up ? (limited ? (m_data >= lim) : (m_data == MAXV)) : (m_data == 0);
        if (stepping) begin
            if (!term) begin
                m_data  = up ? (m_data + 1) % MODV : (m_data + MODV - 1) % MODV;
                m_match = (m_data == cmp);
            end else begin
                m_tc = 1;
                if (mode == 2) begin
                    m_run = 0;
                end else begin
                    if (mode == 1) m_data = up ? 0 : lim;
                    else           m_data = up ? 0 : MAXV;
                    m_match = (m_data == cmp);
                end
            end
        end
        if (stepping && term)        m_ovf = 1;
        else if (bus.i_clr_flags)    m_ovf = 0;
    endtask

    task automatic step_check();
        @(posedge clk);
        model_edge();
        #1;
        check("data",    bus.o_data,    m_data);
        check("tc",      bus.o_tc,      m_tc);
        check("match",   bus.o_match,   m_match);
        check("ovf",     bus.o_ovf,     m_ovf);
        check("running", bus.o_running, m_run);
    endtask

    task automatic run(input int n);
        repeat (n) step_check();
    endtask

    task automatic load(input int value);
        bus.i_le   = 1'b1;
        bus.i_data = DW'(value);
        step_check();
        bus.i_le   = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.i_en       = 1'b1;
        bus.i_le       = 1'b0;
        bus.i_data     = '0;
        bus.i_dir      = 1'b0;
        bus.i_mode     = 2'b00;
        bus.i_limit    = '0;
        bus.i_prescale = '0;
        bus.i_compare  = 4'd4;
        bus.i_clr_flags = 1'b0;
        m_data = 0; m_pcnt = 0; m_tc = 0; m_match = 0; m_ovf = 0; m_run = 1;

        run(2);
        check("rst_data", bus.o_data, 0);
        check("rst_running", bus.o_running, 1);
        rst = 1'b1;

        // Free-run up with compare at 4, wrap 15->0, clear racing the wrap.
        run(4);
        check("fr_match4", bus.o_match, 1);
        run(11);
        check("fr_at15", bus.o_data, 15);
        bus.i_clr_flags = 1'b1;
        run(1);
        bus.i_clr_flags = 1'b0;
        check("fr_wrap_data", bus.o_data, 0);
        check("fr_wrap_tc", bus.o_tc, 1);
        check("fr_ovf_beats_clr", bus.o_ovf, 1);
        run(3);
        check("fr_ovf_sticky", bus.o_ovf, 1);
        bus.i_clr_flags = 1'b1;
        run(1);
        bus.i_clr_flags = 1'b0;
        check("fr_ovf_cleared", bus.o_ovf, 0);
        load(4);
        check("load_match", bus.o_match, 1);

        // Modulo up, limit 5, prescale 2.
        bus.i_mode = 2'b01; bus.i_limit = 4'd5; bus.i_prescale = 3'd2; bus.i_compare = 4'd15;
        load(0);
        run(18);
        check("mod_wrap_data", bus.o_data, 0);
        check("mod_wrap_tc", bus.o_tc, 1);
        load(9);
        run(3);
        check("mod_above_limit_data", bus.o_data, 0);
        check("mod_above_limit_tc", bus.o_tc, 1);

        // Modulo down, limit 7.
        bus.i_dir = 1'b1; bus.i_limit = 4'd7; bus.i_prescale = 3'd0;
        load(3);
        run(4);
        check("mod_dn_reload", bus.o_data, 7);
        check("mod_dn_tc", bus.o_tc, 1);
        run(3);

        // One-shot up, limit 3.
        bus.i_dir = 1'b0; bus.i_mode = 2'b10; bus.i_limit = 4'd3;
        load(0);
        run(3);
        check("os_at3", bus.o_data, 3);
        run(1);
        check("os_tc", bus.o_tc, 1);
        check("os_expired", bus.o_running, 0);
        run(4);
        check("os_hold", bus.o_data, 3);
        load(0);
        check("os_restart", bus.o_running, 1);

        // Reset together with load while ovf is set.
        bus.i_mode = 2'b00;
        load(14);
        run(2);
        check("pre_rst_ovf", bus.o_ovf, 1);
        rst = 1'b0; bus.i_le = 1'b1; bus.i_data = 4'd9;
        run(1);
        check("rst_le_data", bus.o_data, 0);
        check("rst_le_ovf", bus.o_ovf, 0);
        rst = 1'b1; bus.i_le = 1'b0;

        // Enable low freezes the prescaler and count.
        bus.i_prescale = 3'd3;
        run(2);
        bus.i_en = 1'b0;
        run(5);
        check("freeze_data", bus.o_data, 0);
        bus.i_en = 1'b1;
        run(1);
        check("freeze_pcnt_held", bus.o_data, 0);
        run(1);
        check("freeze_resume", bus.o_data, 1);

        // Randomized traffic; configuration changes in bursts.
        for (int blk = 0; blk < 100; blk++) begin
            bus.i_dir      = 1'($urandom_range(0, 1));
            bus.i_mode     = 2'($urandom_range(0, 3));
            bus.i_limit    = DW'($urandom_range(0, MAXV));
            bus.i_compare  = DW'($urandom_range(0, MAXV));
            bus.i_prescale = PW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, PMOD - 1)
                                                             : $urandom_range(0, 1));
            for (int i = 0; i < 20; i++) begin
                rst             = ($urandom_range(0, 63) != 0);
                bus.i_en        = ($urandom_range(0, 7) != 0);
                bus.i_le        = ($urandom_range(0, 15) == 0);
                bus.i_data      = DW'($urandom_range(0, MAXV));
                bus.i_clr_flags = ($urandom_range(0, 7) == 0);
                step_check();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
